vga_timing_out: RTL and testbench

//  Raster timing generator and VGA output stage of the display pipeline.

---
 rtl/vga_timing_out.sv | 133 +++++++++++++
 tb/tb_vga_timing_out.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_out.sv
// Raster timing generator plus VGA output stage: emits x/y to the colour mux,
// takes its r/g/b back and registers it to the DAC with sync/blank aligned.
module vga_timing_out #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_en,
    output logic       move,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_MOVE = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Sync bits are carried active-high so an all-zero (reset) delay line
    // means "no sync", avoiding a spurious pulse right after reset.
    typedef struct packed {
        logic act;
        logic hsync;
        logic vsync;
    } rast_t;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    rast_t         raw, dly;

    always_comb begin
        pix_en    = (div_cnt_q == DIV_LAST);
        vga_clk   = (div_cnt_q >= DIV_HALF);
        div_cnt_d = pix_en ? '0 : div_cnt_q + DW'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
        move      = pix_en && (h_cnt_q == H_LAST) && (v_cnt_q == V_MOVE);
        raw.act   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        raw.hsync = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        raw.vsync = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    assign x          = h_cnt_q;
    assign y          = v_cnt_q;
    assign vga_sync_n = 1'b0;

    // Match the colour mux latency so sync/blank line up with r/g/b_in.
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign dly = raw;
        end else begin : g_dly
            rast_t [PIPE_LAT-1:0] pipe_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= '0;
                end else if (pix_en) begin
                    pipe_q[0] <= raw;
                    for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign dly = pipe_q[PIPE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
        end else if (pix_en) begin
            vga_r       <= dly.act ? r_in : 8'h00;
            vga_g       <= dly.act ? g_in : 8'h00;
            vga_b       <= dly.act ? b_in : 8'h00;
            vga_blank_n <= dly.act;
            vga_hs      <= !dly.hsync;
            vga_vs      <= !dly.vsync;
        end
    end
endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench on a shrunken raster (15 x 8 positions, 120 ticks/frame).
module tb_vga_timing_out;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x, y;
    logic       pix_en, move;
    logic [7:0] r_in, g_in, b_in;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    vga_timing_out #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pix_en(pix_en), .move(move),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
    );

    always #5 clk = ~clk;

    // Colour mux stand-in: one pixel tick of latency, ramp = previous x.
    logic       ramp = 1'b0;
    logic [7:0] mux_q = 8'h00;
    always @(posedge clk) if (pix_en) mux_q <= x[7:0];
    assign r_in = ramp ? mux_q : 8'hFF;
    assign g_in = 8'h80;
    assign b_in = 8'h01;

    int errs = 0, checks = 0, nedge = 0, n = 0;
    int hs_lo, vs_lo, blk, pe, mv, mv1, mv2, bad, rff;
    int hs_fall, vs_fall, bl_rise, bl_fall;
    logic hs_p, vs_p, bl_p;
    logic [7:0] samp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic ne();
        @(negedge clk);
        nedge++;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_blank", vga_blank_n, 0);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_xy", {x, y}, 0);
        chk("rst_pix_en", pix_en, 0);
        chk("rst_move", move, 0);
        chk("rst_vga_clk", vga_clk, 0);
        chk("rst_sync_n", vga_sync_n, 0);

        rst_n = 1'b1;
        nedge = 0;
        ne();
        chk("pix_en_first", pix_en, 1);
        chk("x_at_first", x, 0);
        chk("vga_clk_hi", vga_clk, 1);
        ne();
        chk("pix_en_gap", pix_en, 0);
        chk("x_after_first", x, 1);
        chk("vga_clk_lo", vga_clk, 0);

        // Two full frames with constant colour in.
        hs_lo = 0; vs_lo = 0; blk = 0; pe = 0; mv = 0; mv1 = -1; mv2 = -1;
        bad = 0; rff = 0; hs_fall = -1; vs_fall = -1; bl_rise = -1; bl_fall = -1;
        hs_p = vga_hs; vs_p = vga_vs; bl_p = vga_blank_n;
        repeat (480) begin
            ne();
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            if (vga_blank_n) blk++;
            if (pix_en) pe++;
            if (vga_r == 8'hFF) rff++;
            if (vga_blank_n ? ({vga_r, vga_g, vga_b} != 24'hFF8001)
                            : ({vga_r, vga_g, vga_b} != 24'h0)) bad++;
            if (move) begin
                mv++;
                if (mv1 < 0) mv1 = nedge; else if (mv2 < 0) mv2 = nedge;
            end
            if (hs_fall < 0 && hs_p && !vga_hs) hs_fall = nedge;
            if (vs_fall < 0 && vs_p && !vga_vs) vs_fall = nedge;
            if (bl_rise < 0 && !bl_p && vga_blank_n) bl_rise = nedge;
            if (bl_fall < 0 && bl_p && !vga_blank_n) bl_fall = nedge;
            hs_p = vga_hs; vs_p = vga_vs; bl_p = vga_blank_n;
        end
        chk("hs_low_clks", hs_lo, 96);
        chk("vs_low_clks", vs_lo, 120);
        chk("blank_hi_clks", blk, 128);
        chk("pix_en_count", pe, 240);
        chk("move_count", mv, 2);
        chk("move_first", mv1, 119);
        chk("move_spacing", mv2 - mv1, 240);
        chk("hs_fall_at", hs_fall, 24);
        chk("vs_fall_at", vs_fall, 154);
        chk("blank_rise_at", bl_rise, 4);
        chk("blank_fall_at", bl_fall, 20);
        chk("rgb_blanking", bad, 0);
        chk("r_ff_clks", rff, 128);

        // Ramp through the delayed mux: each visible pixel shows its own index.
        ramp = 1'b1;
        repeat (240) begin
            ne();
            if (pix_en && vga_blank_n) samp.push_back(vga_r);
            if (pix_en && vga_blank_n && samp.size() == 1) chk("ramp_gb", {vga_g, vga_b}, 16'h8001);
        end
        chk("ramp_count", samp.size(), 32);
        foreach (samp[i]) chk($sformatf("ramp_px%0d", i), samp[i], i % 8);

        // Mid-line reset at (5,2).
        n = 0;
        while (!(x == 10'd5 && y == 10'd2) && n < 400) begin
            ne();
            n++;
        end
        chk("reach_mid", n < 400, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_xy", {x, y}, 0);
        chk("mid_rst_hsvs", {vga_hs, vga_vs}, 2'b11);
        chk("mid_rst_blank", vga_blank_n, 0);
        chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("mid_rst_pe_mv", {pix_en, move, vga_clk}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nedge = 0;
        ne();
        chk("restart_xy", {x, y}, 0);
        chk("restart_pix_en", pix_en, 1);
        while (!move && nedge < 600) ne();
        chk("restart_move_at", nedge, 119);
        chk("restart_move_xy", {x, y}, {10'd14, 10'd3});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
